// File: rtl/evm_result_tally_if.sv
// Readout port of evm_result_tally: one tally word per valid/ready transfer.
// rd_parity is present only when EVM_TALLY_PARITY_EN is defined.
interface evm_result_tally_if #(
  parameter int CNT_W = 7
);
  logic             rd_valid;
  logic             rd_ready;
  logic [1:0]       rd_idx;
  logic [CNT_W-1:0] rd_data;
  logic             rd_last;
`ifdef EVM_TALLY_PARITY_EN
  logic             rd_parity;

  modport master (
    output rd_valid,
    output rd_idx,
    output rd_data,
    output rd_last,
    output rd_parity,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_idx,
    input  rd_data,
    input  rd_last,
    input  rd_parity,
    output rd_ready
  );
`else
  modport master (
    output rd_valid,
    output rd_idx,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_idx,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );
`endif
endinterface

// File: rtl/evm_result_tally.sv
// Vote tally: counts rising-edge vote events while the poll is open, then picks a
// winner and streams the four tallies out. EVM_TALLY_PARITY_EN adds rd_parity.
module evm_result_tally #(
  parameter int CNT_W = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                party_led_i,
  input  logic                      invalid_vote_i,
  input  logic                      poll_open_i,
  input  logic                      close_poll_i,
  evm_result_tally_if.master        rd_if,
  output logic [1:0]                winner_o,
  output logic                      tie_o,
  output logic                      result_done_o,
  output logic                      overflow_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_COMPARE = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic even_parity(input logic [CNT_W-1:0] d);
    return ^d;
  endfunction

  state_e                  state_q, state_d;
  logic [3:0][CNT_W-1:0]   tally_q, tally_d;
  logic [2:0]              party_prev_q;
  logic                    inv_prev_q;
  logic                    overflow_q, overflow_d;
  logic [1:0]              winner_q, winner_d;
  logic                    tie_q, tie_d;
  logic                    result_done_q, result_done_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [1:0]              rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]        rd_data_q, rd_data_d;
  logic                    rd_last_q, rd_last_d;
`ifdef EVM_TALLY_PARITY_EN
  logic                    rd_parity_q, rd_parity_d;
`endif

  logic [2:0]              party_rise_s;
  logic                    inv_rise_s;
  logic                    multi_rise_s;
  logic [3:0]              inc_s;
  logic [1:0]              win_idx_s;
  logic [CNT_W-1:0]        max_s;
  logic [1:0]              n_at_max_s;
  logic [1:0]              next_idx_s;

  // Edge detection and classification of the vote indications
  always_comb begin
    party_rise_s = party_led_i & ~party_prev_q;
    inv_rise_s   = invalid_vote_i & ~inv_prev_q;
    multi_rise_s = (party_rise_s[0] & party_rise_s[1]) |
                   (party_rise_s[0] & party_rise_s[2]) |
                   (party_rise_s[1] & party_rise_s[2]);
    inc_s[3]     = inv_rise_s | multi_rise_s;
    if (!inv_rise_s && !multi_rise_s) begin
      inc_s[2:0] = party_rise_s;
    end else begin
      inc_s[2:0] = 3'b000;
    end
  end

  // Maximum search over the party tallies; strict compare keeps the lowest index
  always_comb begin
    win_idx_s = 2'd0;
    max_s     = tally_q[0];
    if (tally_q[1] > max_s) begin
      win_idx_s = 2'd1;
      max_s     = tally_q[1];
    end else begin
      win_idx_s = win_idx_s;
    end
    if (tally_q[2] > max_s) begin
      win_idx_s = 2'd2;
      max_s     = tally_q[2];
    end else begin
      win_idx_s = win_idx_s;
    end
    n_at_max_s = {1'b0, (tally_q[0] == max_s)} +
                 {1'b0, (tally_q[1] == max_s)} +
                 {1'b0, (tally_q[2] == max_s)};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    tally_d       = tally_q;
    overflow_d    = overflow_q;
    winner_d      = winner_q;
    tie_d         = tie_q;
    result_done_d = result_done_q;
    rd_valid_d    = rd_valid_q;
    rd_idx_d      = rd_idx_q;
    rd_data_d     = rd_data_q;
    rd_last_d     = rd_last_q;
    next_idx_s    = rd_idx_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (poll_open_i) begin
          state_d       = S_COUNT;
          tally_d       = '0;
          overflow_d    = 1'b0;
          winner_d      = 2'd3;
          tie_d         = 1'b0;
          result_done_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COUNT: begin
        for (int k = 0; k < 4; k++) begin
          if (inc_s[k]) begin
            if (tally_q[k] == CNT_MAX) begin
              overflow_d = 1'b1;
            end else begin
              tally_d[k] = tally_q[k] + CNT_ONE;
            end
          end else begin
            tally_d[k] = tally_d[k];
          end
        end
        // A dropped poll_open without a close pulse still ends the session
        if (close_poll_i || !poll_open_i) begin
          state_d = S_COMPARE;
        end else begin
          state_d = S_COUNT;
        end
      end

      S_COMPARE: begin
        if (max_s == '0) begin
          winner_d = 2'd3;
          tie_d    = 1'b0;
        end else begin
          winner_d = win_idx_s;
          tie_d    = (n_at_max_s >= 2'd2);
        end
        state_d    = S_STREAM;
        rd_valid_d = 1'b1;
        rd_idx_d   = 2'd0;
        rd_data_d  = tally_q[0];
        rd_last_d  = 1'b0;
      end

      S_STREAM: begin
        if (rd_valid_q && rd_if.rd_ready) begin
          if (rd_last_q) begin
            rd_valid_d    = 1'b0;
            result_done_d = 1'b1;
            state_d       = S_DONE;
          end else begin
            rd_idx_d  = next_idx_s;
            rd_data_d = tally_q[next_idx_s];
            rd_last_d = (rd_idx_q == 2'd2);
          end
        end else begin
          state_d = S_STREAM;
        end
      end

      S_DONE: begin
        if (!poll_open_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef EVM_TALLY_PARITY_EN
    rd_parity_d = even_parity(rd_data_d);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Tallies, input history, result flags and readout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally_q       <= '0;
      party_prev_q  <= 3'b000;
      inv_prev_q    <= 1'b0;
      overflow_q    <= 1'b0;
      winner_q      <= 2'd3;
      tie_q         <= 1'b0;
      result_done_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_idx_q      <= 2'd0;
      rd_data_q     <= '0;
      rd_last_q     <= 1'b0;
`ifdef EVM_TALLY_PARITY_EN
      rd_parity_q   <= 1'b0;
`endif
    end else begin
      tally_q       <= tally_d;
      party_prev_q  <= party_led_i;
      inv_prev_q    <= invalid_vote_i;
      overflow_q    <= overflow_d;
      winner_q      <= winner_d;
      tie_q         <= tie_d;
      result_done_q <= result_done_d;
      rd_valid_q    <= rd_valid_d;
      rd_idx_q      <= rd_idx_d;
      rd_data_q     <= rd_data_d;
      rd_last_q     <= rd_last_d;
`ifdef EVM_TALLY_PARITY_EN
      rd_parity_q   <= rd_parity_d;
`endif
    end
  end

  assign rd_if.rd_valid = rd_valid_q;
  assign rd_if.rd_idx   = rd_idx_q;
  assign rd_if.rd_data  = rd_data_q;
  assign rd_if.rd_last  = rd_last_q;
`ifdef EVM_TALLY_PARITY_EN
  assign rd_if.rd_parity = rd_parity_q;
`endif
  assign winner_o      = winner_q;
  assign tie_o         = tie_q;
  assign result_done_o = result_done_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_evm_result_tally.sv
// Scoreboard bench for evm_result_tally: stimulus pushes expected readout words,
// a negedge monitor pops and compares them on every valid/ready transfer.
module tb_evm_result_tally;

  typedef struct packed {
    logic [1:0] idx;
    logic [6:0] data;
    logic       last;
  } word_t;

  logic       clk;
  logic       rst;
  logic [2:0] party_led;
  logic       invalid_vote;
  logic       poll_open;
  logic       close_poll;
  logic [1:0] winner;
  logic       tie;
  logic       result_done;
  logic       overflow;

  int         checks;
  int         failures;
  word_t      exp_q[$];
  word_t      held_w;
  logic       stall_seen;
  int         cyc;

  evm_result_tally_if #(.CNT_W(7)) rif ();

  evm_result_tally #(.CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .party_led_i   (party_led),
    .invalid_vote_i(invalid_vote),
    .poll_open_i   (poll_open),
    .close_poll_i  (close_poll),
    .rd_if         (rif),
    .winner_o      (winner),
    .tie_o         (tie),
    .result_done_o (result_done),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic vote(input logic [2:0] p, input logic inv);
    party_led    = p;
    invalid_vote = inv;
    step();
    party_led    = 3'b000;
    invalid_vote = 1'b0;
    step();
  endtask

  task automatic push_words(input int t0, input int t1, input int t2, input int t3);
    exp_q.push_back('{idx: 2'd0, data: 7'(t0), last: 1'b0});
    exp_q.push_back('{idx: 2'd1, data: 7'(t1), last: 1'b0});
    exp_q.push_back('{idx: 2'd2, data: 7'(t2), last: 1'b0});
    exp_q.push_back('{idx: 2'd3, data: 7'(t3), last: 1'b1});
  endtask

  task automatic open_session();
    poll_open = 1'b1;
    step();
    chk("open_result_done", 32'(result_done), 32'd0);
    chk("open_overflow", 32'(overflow), 32'd0);
    chk("open_winner", 32'(winner), 32'd3);
    chk("open_rd_valid", 32'(rif.rd_valid), 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!result_done && n < 60) begin
      step();
      n++;
    end
    chk("result_done", 32'(result_done), 32'd1);
    chk("words_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic end_session(input int w, input int t, input int ov);
    chk("winner", 32'(winner), 32'(w));
    chk("tie", 32'(tie), 32'(t));
    chk("overflow", 32'(overflow), 32'(ov));
    chk("done_rd_valid", 32'(rif.rd_valid), 32'd0);
    poll_open = 1'b0;
    step();
    chk("idle_result_done", 32'(result_done), 32'd1);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_rd_valid"}, 32'(rif.rd_valid), 32'd0);
    chk({nm, "_rd_idx"}, 32'(rif.rd_idx), 32'd0);
    chk({nm, "_rd_data"}, 32'(rif.rd_data), 32'd0);
    chk({nm, "_rd_last"}, 32'(rif.rd_last), 32'd0);
    chk({nm, "_winner"}, 32'(winner), 32'd3);
    chk({nm, "_tie"}, 32'(tie), 32'd0);
    chk({nm, "_result_done"}, 32'(result_done), 32'd0);
    chk({nm, "_overflow"}, 32'(overflow), 32'd0);
`ifdef EVM_TALLY_PARITY_EN
    chk({nm, "_rd_parity"}, 32'(rif.rd_parity), 32'd0);
`endif
  endtask

  // Monitor: compares each transferred word and checks stability across stalls
  always @(negedge clk) begin
    word_t cur;
    word_t e;
    cur = '{idx: rif.rd_idx, data: rif.rd_data, last: rif.rd_last};
    if (!rst && rif.rd_valid) begin
      if (stall_seen) begin
        chk("stall_stable", 32'(cur), 32'(held_w));
      end
      if (rif.rd_ready) begin
        stall_seen = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(cur), 32'h3ff);
        end else begin
          e = exp_q.pop_front();
          chk("word_idx", 32'(cur.idx), 32'(e.idx));
          chk("word_data", 32'(cur.data), 32'(e.data));
          chk("word_last", 32'(cur.last), 32'(e.last));
`ifdef EVM_TALLY_PARITY_EN
          chk("word_parity", 32'(rif.rd_parity), 32'(^e.data));
`endif
        end
      end else begin
        stall_seen = 1'b1;
        held_w     = cur;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    logic [6:0] pat;
    checks       = 0;
    failures     = 0;
    stall_seen   = 1'b0;
    held_w       = '0;
    rst          = 1'b1;
    party_led    = 3'b000;
    invalid_vote = 1'b0;
    poll_open    = 1'b0;
    close_poll   = 1'b0;
    rif.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset("reset");
    rst = 1'b0;
    step();

    // Basic count with full-throughput readout and latency check
    rif.rd_ready = 1'b1;
    open_session();
    vote(3'b001, 1'b0);
    vote(3'b001, 1'b0);
    vote(3'b010, 1'b0);
    vote(3'b010, 1'b0);
    vote(3'b100, 1'b0);
    push_words(2, 2, 1, 0);
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    wait_done(cyc);
    chk("close_to_done_cycles", 32'(cyc), 32'd6);
    end_session(0, 1, 0);

    // Invalid handling: invalid pulse, multi-party rise, then party2
    open_session();
    vote(3'b000, 1'b1);
    vote(3'b011, 1'b0);
    vote(3'b100, 1'b0);
    push_words(0, 0, 1, 2);
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    wait_done(cyc);
    end_session(2, 0, 0);

    // Held level counts once, read out under backpressure
    open_session();
    party_led = 3'b001;
    repeat (20) step();
    party_led = 3'b000;
    step();
    push_words(1, 0, 0, 0);
    rif.rd_ready = 1'b0;
    close_poll   = 1'b1;
    step();
    close_poll = 1'b0;
    step();
    chk("stream_valid", 32'(rif.rd_valid), 32'd1);
    pat = 7'b1110100;
    for (int i = 0; i < 7; i++) begin
      rif.rd_ready = pat[6-i];
      step();
    end
    rif.rd_ready = 1'b1;
    wait_done(cyc);
    end_session(0, 0, 0);

    // Saturation on party1, closed by dropping poll_open
    open_session();
    for (int i = 0; i < 130; i++) begin
      vote(3'b010, 1'b0);
    end
    chk("ovf_before_close", 32'(overflow), 32'd1);
    push_words(0, 127, 0, 0);
    poll_open = 1'b0;
    step();
    poll_open = 1'b1;
    wait_done(cyc);
    end_session(1, 0, 1);

    // Reset after the word-1 transfer, then an empty session
    open_session();
    vote(3'b001, 1'b0);
    push_words(1, 0, 0, 0);
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_idx", 32'(rif.rd_idx), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    exp_q.delete();
    poll_open = 1'b0;
    rst       = 1'b0;
    step();
    open_session();
    push_words(0, 0, 0, 0);
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    wait_done(cyc);
    end_session(3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
